snake_motion_ctrl: RTL and testbench
====================================

Name: snake_motion_ctrl

Overview:
- Per-frame game sequencer for the two-player snake display.
- Captures direction keys for both players, rejects 180-degree reversals, and steps both head positions once per frame with screen wrap-around.
- Detects head-head and head-obstacle collisions and latches a game-over/winner result.
- Outputs feed the head-sprite renderer: positions, plus direction codes used as its sprite-mux selects.

Parameters:
STEP, 2, pixels moved per frame per snake
X_MIN, 12, leftmost legal head centre X
X_MAX, 627, rightmost legal head centre X
Y_MIN, 12, topmost legal head centre Y
Y_MAX, 467, bottommost legal head centre Y

Ports:
Clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous active-high reset
frame_clk  input  1  vsync-rate strobe, asynchronous to Clk
keycode  input  16  two USB keycode bytes, [7:0] and [15:8]; 0x00 = no key
rand_cord  input  20  obstacle centre: X=[19:10], Y=[9:0]
snakeX_pos  output  10  P1 head centre X
snakeY_pos  output  10  P1 head centre Y
snake2X_pos  output  10  P2 head centre X
snake2Y_pos  output  10  P2 head centre Y
dir1  output  2  P1 committed direction: 0=up, 1=left, 2=down, 3=right
dir2  output  2  P2 committed direction, same encoding
game_over  output  1  high while in OVER state
winner  output  2  00=none, 01=P1, 10=P2, 11=draw

Behaviour:
- Reset values:
  - P1 = (160,240), dir1=3.
  - P2 = (480,240), dir2=1.
  - pend1/pend2 = committed dirs.
  - game_over=0, winner=00, state=IDLE.
  - Sync flops = 0.
- frame_clk handling: passes through a 2-flop synchroniser, then rising-edge detect. This gives one-cycle internal pulse tick, 3 Clk after the input edge.
- Key capture, every cycle in any state except OVER. Each byte is decoded independently:
  - P1: 0x1A up, 0x04 left, 0x16 down, 0x07 right.
  - P2: 0x52 up, 0x50 left, 0x51 down, 0x4F right.
  - Unmapped codes are ignored.
  - If both bytes map to the same player, byte [7:0] wins.
  - The decoded direction loads pendN unless it equals the reverse of the committed dirN (up<->down, left<->right). Reversals are dropped silently.
  - Multiple turns within one frame: the last legal one wins. Legality is always checked against committed dirN, never pendN.
- FSM states: IDLE, MOVE, CHECK, OVER.
  - IDLE: on tick -> MOVE. Otherwise stay.
  - MOVE (1 cycle):
    - dirN <= pendN.
    - Each head steps STEP pixels in the new direction.
    - -> CHECK.
  - CHECK (1 cycle): evaluates collisions on the new registered positions.
    - Any hit: set winner, game_over<=1, -> OVER.
    - No hit: -> IDLE.
  - OVER:
    - Positions and dirs are frozen; tick is ignored.
    - Key 0x2C (space) in either byte reloads all reset values and clears game_over/winner, -> IDLE.
- Tick arriving in MOVE/CHECK/OVER is dropped, not queued.
- Latency from tick:
  - New positions visible 1 Clk later (end of MOVE).
  - game_over/winner visible 2 Clk later.
- Wrap-around rules:
  - Right: if X+STEP > X_MAX then X <= X_MIN, else X+STEP.
  - Left: if X < X_MIN+STEP then X <= X_MAX, else X-STEP.
  - Y uses the same rules with Y_MIN/Y_MAX.
  - All compares are unsigned 11-bit to avoid overflow.
- Collision rules:
  - Head-head: |X1-X2| < 24 and |Y1-Y2| < 24. Both lose -> winner=11.
  - Obstacle for player N: |XN-rx| <= 32 and |YN-ry| <= 24 -> N loses.
  - Only P1 loses -> 10. Only P2 loses -> 01. Both lose -> 11.
  - Head-head overrides obstacle results.
  - Absolute differences are computed on 11-bit signed-extended values.
- Asynchronous reset at any point, including mid-MOVE, returns every register to its reset value immediately. No partial position update survives.

Test Plan:
- Reset, then 3 ticks with no keys:
  - P1 X: 160->162->164->166.
  - P2 X: 480->478->476->474.
  - Y unchanged at 240; game_over=0.
- keycode=0x0004 (P1 reverse left) then tick: rejected; dir1 stays 3, P1 X +2. Then keycode=0x001A, tick: dir1=0, P1 Y 240->238.
- keycode=0x1A16 (both bytes P1) then tick: low byte 0x16 wins; dir1=2, P1 Y +2.
- Force P1 X=626, dir right, tick: X wraps to 12. P2 moving left from X=13: wraps to 627.
- Set rand_cord=(200,240), place P1 at 166 moving right, tick repeatedly:
  - When X reaches 168, game_over=1 two cycles after tick, winner=10.
  - Further ticks leave positions frozen.
  - keycode=0x002C: reset positions restored, game_over=0.
- Heads approaching on the same row: game_over asserts on the first tick where |X1-X2| < 24, winner=11. Asserting reset during MOVE yields reset positions on the next observed cycle.

Source files
------------

// File: rtl/snake_motion_ctrl.sv
// Per-frame sequencer for the two-player snake game: direction capture,
// wrap-around head stepping, collision detection and game-over/winner latch.
module snake_motion_ctrl #(
    parameter int STEP  = 2,
    parameter int X_MIN = 12,
    parameter int X_MAX = 627,
    parameter int Y_MIN = 12,
    parameter int Y_MAX = 467
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic [19:0] rand_cord,
    output logic [9:0]  snakeX_pos,
    output logic [9:0]  snakeY_pos,
    output logic [9:0]  snake2X_pos,
    output logic [9:0]  snake2Y_pos,
    output logic [1:0]  dir1,
    output logic [1:0]  dir2,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam logic [1:0]  UP    = 2'd0;
    localparam logic [1:0]  LEFT  = 2'd1;
    localparam logic [1:0]  DOWN  = 2'd2;
    localparam logic [1:0]  RIGHT = 2'd3;

    localparam logic [9:0]  P1_X0 = 10'd160;
    localparam logic [9:0]  P1_Y0 = 10'd240;
    localparam logic [9:0]  P2_X0 = 10'd480;
    localparam logic [9:0]  P2_Y0 = 10'd240;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] X_LO   = 11'(X_MIN);
    localparam logic [10:0] X_HI   = 11'(X_MAX);
    localparam logic [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic [10:0] Y_HI   = 11'(Y_MAX);

    localparam logic [10:0] HEAD_SPAN = 11'd24;
    localparam logic [10:0] OBS_X_SPAN = 11'd32;
    localparam logic [10:0] OBS_Y_SPAN = 11'd24;

    localparam logic [7:0]  KEY_SPACE = 8'h2C;

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, OVER} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        frame_sync_p0;
    logic        frame_sync_p1;
    logic        frame_sync_p2;
    logic        tick;

    logic [1:0]  pend1;
    logic [1:0]  pend2;

    logic [2:0]  key1_lo;
    logic [2:0]  key1;
    logic [2:0]  key2_lo;
    logic [2:0]  key2;
    logic        load1;
    logic        load2;
    logic        space;

    logic [19:0] next1;
    logic [19:0] next2;

    logic [9:0]  obs_x;
    logic [9:0]  obs_y;
    logic        hit_head;
    logic        hit_obs1;
    logic        hit_obs2;
    logic        hit_any;
    logic [1:0]  winner_nxt;

    logic        key_en;
    logic        do_move;
    logic        do_hit;
    logic        restart;

    function automatic logic [9:0] wrap_inc(input logic [9:0] v,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
        logic [10:0] sum;
        sum = {1'b0, v} + STEP_W;
        return (sum > hi) ? lo[9:0] : sum[9:0];
    endfunction

    function automatic logic [9:0] wrap_dec(input logic [9:0] v,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
        logic [10:0] ext;
        logic [10:0] diff;
        ext  = {1'b0, v};
        diff = ext - STEP_W;
        return (ext < lo + STEP_W) ? hi[9:0] : diff[9:0];
    endfunction

    // Returns {x, y} after one step in direction d, wrapping at the play-field edges.
    function automatic logic [19:0] step_xy(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic [1:0] d);
        logic [19:0] r;
        case (d)
            UP:      r = {x, wrap_dec(y, Y_LO, Y_HI)};
            LEFT:    r = {wrap_dec(x, X_LO, X_HI), y};
            DOWN:    r = {x, wrap_inc(y, Y_LO, Y_HI)};
            default: r = {wrap_inc(x, X_LO, X_HI), y};
        endcase
        return r;
    endfunction

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 11'(-d) : 11'(d);
    endfunction

    // {valid, dir}
    function automatic logic [2:0] map_p1(input logic [7:0] code);
        case (code)
            8'h1A:   return {1'b1, UP};
            8'h04:   return {1'b1, LEFT};
            8'h16:   return {1'b1, DOWN};
            8'h07:   return {1'b1, RIGHT};
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] map_p2(input logic [7:0] code);
        case (code)
            8'h52:   return {1'b1, UP};
            8'h50:   return {1'b1, LEFT};
            8'h51:   return {1'b1, DOWN};
            8'h4F:   return {1'b1, RIGHT};
            default: return 3'b000;
        endcase
    endfunction

    // frame_clk synchroniser and rising-edge detect
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            frame_sync_p0 <= 1'b0;
            frame_sync_p1 <= 1'b0;
            frame_sync_p2 <= 1'b0;
        end else begin
            frame_sync_p0 <= frame_clk;
            frame_sync_p1 <= frame_sync_p0;
            frame_sync_p2 <= frame_sync_p1;
        end
    end

    assign tick = frame_sync_p1 & ~frame_sync_p2;

    // Low byte takes priority when both bytes carry a key for the same player.
    always_comb begin
        key1_lo = map_p1(keycode[7:0]);
        key1    = key1_lo[2] ? key1_lo : map_p1(keycode[15:8]);
        key2_lo = map_p2(keycode[7:0]);
        key2    = key2_lo[2] ? key2_lo : map_p2(keycode[15:8]);
        load1   = key1[2] && (key1[1:0] != (dir1 ^ 2'b10));
        load2   = key2[2] && (key2[1:0] != (dir2 ^ 2'b10));
        space   = (keycode[7:0] == KEY_SPACE) || (keycode[15:8] == KEY_SPACE);
    end

    always_comb begin
        next1 = step_xy(snakeX_pos, snakeY_pos, pend1);
        next2 = step_xy(snake2X_pos, snake2Y_pos, pend2);
    end

    always_comb begin
        obs_x    = rand_cord[19:10];
        obs_y    = rand_cord[9:0];
        hit_head = (abs_diff(snakeX_pos, snake2X_pos) < HEAD_SPAN) &&
                   (abs_diff(snakeY_pos, snake2Y_pos) < HEAD_SPAN);
        hit_obs1 = (abs_diff(snakeX_pos, obs_x) <= OBS_X_SPAN) &&
                   (abs_diff(snakeY_pos, obs_y) <= OBS_Y_SPAN);
        hit_obs2 = (abs_diff(snake2X_pos, obs_x) <= OBS_X_SPAN) &&
                   (abs_diff(snake2Y_pos, obs_y) <= OBS_Y_SPAN);
        hit_any  = hit_head | hit_obs1 | hit_obs2;
        // Bit 1 set means P1 lost (P2 wins), bit 0 set means P2 lost.
        winner_nxt = hit_head ? 2'b11 : {hit_obs1, hit_obs2};
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = MOVE;
            MOVE:    state_nxt = CHECK;
            CHECK:   state_nxt = hit_any ? OVER : IDLE;
            OVER:    if (space) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        key_en  = (state != OVER);
        do_move = (state == MOVE);
        do_hit  = (state == CHECK) && hit_any;
        restart = (state == OVER) && space;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            snakeX_pos  <= P1_X0;
            snakeY_pos  <= P1_Y0;
            snake2X_pos <= P2_X0;
            snake2Y_pos <= P2_Y0;
            dir1        <= RIGHT;
            dir2        <= LEFT;
            pend1       <= RIGHT;
            pend2       <= LEFT;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else if (restart) begin
            snakeX_pos  <= P1_X0;
            snakeY_pos  <= P1_Y0;
            snake2X_pos <= P2_X0;
            snake2Y_pos <= P2_Y0;
            dir1        <= RIGHT;
            dir2        <= LEFT;
            pend1       <= RIGHT;
            pend2       <= LEFT;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            if (key_en && load1) pend1 <= key1[1:0];
            if (key_en && load2) pend2 <= key2[1:0];
            if (do_move) begin
                dir1        <= pend1;
                dir2        <= pend2;
                snakeX_pos  <= next1[19:10];
                snakeY_pos  <= next1[9:0];
                snake2X_pos <= next2[19:10];
                snake2Y_pos <= next2[9:0];
            end
            if (do_hit) begin
                game_over <= 1'b1;
                winner    <= winner_nxt;
            end
        end
    end

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Scoreboard bench for snake_motion_ctrl: a frame-level game model predicts
// head positions, directions and result after each frame or probe.
module tb_snake_motion_ctrl;

    localparam int STEP  = 2;
    localparam int X_MIN = 12;
    localparam int X_MAX = 627;
    localparam int Y_MIN = 12;
    localparam int Y_MAX = 467;
    localparam logic [19:0] FAR = {10'd0, 10'd1000};

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        probe = 1'b0;
    logic [15:0] keycode = 16'h0000;
    logic [19:0] rand_cord = FAR;
    logic [9:0]  snakeX_pos, snakeY_pos, snake2X_pos, snake2Y_pos;
    logic [1:0]  dir1, dir2, winner;
    logic        game_over;

    snake_motion_ctrl dut (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode),
        .rand_cord(rand_cord), .snakeX_pos(snakeX_pos), .snakeY_pos(snakeY_pos),
        .snake2X_pos(snake2X_pos), .snake2Y_pos(snake2Y_pos), .dir1(dir1), .dir2(dir2),
        .game_over(game_over), .winner(winner)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x1; int y1; int x2; int y2; int d1; int d2; int go; int win; int id;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   rec_id = 0;

    // Game model: direction 0=up,1=left,2=down,3=right
    int m_x1, m_y1, m_x2, m_y2, m_d1, m_d2, m_p1, m_p2, m_over, m_win;
    int DX[4] = '{0, -STEP, 0, STEP};
    int DY[4] = '{-STEP, 0, STEP, 0};
    int key_tbl[9] = '{'h1A, 'h04, 'h16, 'h07, 'h52, 'h50, 'h51, 'h4F, 'h00};

    task automatic m_reset();
        m_x1 = 160; m_y1 = 240; m_x2 = 480; m_y2 = 240;
        m_d1 = 3; m_d2 = 1; m_p1 = 3; m_p2 = 1;
        m_over = 0; m_win = 0;
    endtask

    function automatic int key_dir(int code, int player);
        int p1_codes[4] = '{'h1A, 'h04, 'h16, 'h07};
        int p2_codes[4] = '{'h52, 'h50, 'h51, 'h4F};
        for (int i = 0; i < 4; i++) begin
            if (player == 1 && code == p1_codes[i]) return i;
            if (player == 2 && code == p2_codes[i]) return i;
        end
        return -1;
    endfunction

    function automatic int wrap(int v, int delta, int lo, int hi);
        int n;
        n = v + delta;
        if (n > hi) return lo;
        if (n < lo) return hi;
        return n;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_key(input logic [15:0] kc);
        int lo, hi, d;
        lo = int'(kc[7:0]);
        hi = int'(kc[15:8]);
        if (m_over != 0) begin
            if (lo == 'h2C || hi == 'h2C) m_reset();
            return;
        end
        d = key_dir(lo, 1);
        if (d < 0) d = key_dir(hi, 1);
        if (d >= 0 && d != (m_d1 + 2) % 4) m_p1 = d;
        d = key_dir(lo, 2);
        if (d < 0) d = key_dir(hi, 2);
        if (d >= 0 && d != (m_d2 + 2) % 4) m_p2 = d;
    endtask

    task automatic m_frame(input int rx, input int ry);
        bit hh, l1, l2;
        if (m_over != 0) return;
        m_d1 = m_p1;
        m_d2 = m_p2;
        m_x1 = wrap(m_x1, DX[m_d1], X_MIN, X_MAX);
        m_y1 = wrap(m_y1, DY[m_d1], Y_MIN, Y_MAX);
        m_x2 = wrap(m_x2, DX[m_d2], X_MIN, X_MAX);
        m_y2 = wrap(m_y2, DY[m_d2], Y_MIN, Y_MAX);
        hh = iabs(m_x1 - m_x2) < 24 && iabs(m_y1 - m_y2) < 24;
        l1 = iabs(m_x1 - rx) <= 32 && iabs(m_y1 - ry) <= 24;
        l2 = iabs(m_x2 - rx) <= 32 && iabs(m_y2 - ry) <= 24;
        if (hh) begin
            m_over = 1; m_win = 3;
        end else if (l1 || l2) begin
            m_over = 1; m_win = (l1 ? 2 : 0) + (l2 ? 1 : 0);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x1 = m_x1; e.y1 = m_y1; e.x2 = m_x2; e.y2 = m_y2;
        e.d1 = m_d1; e.d2 = m_d2; e.go = m_over; e.win = m_win; e.id = rec_id;
        rec_id++;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int id, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s rec=%0d got=%0d expected=%0d", nm, id, got, want);
        end
    endtask

    // Monitor: a frame result is stable 6 Clk after frame_clk rises; probes sample next cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk or posedge probe);
            if (probe) begin
                @(negedge Clk);
            end else begin
                repeat (6) @(posedge Clk);
                @(negedge Clk);
            end
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sample_without_expectation got=sample expected=none");
            end else begin
                e = q.pop_front();
                chk("p1_x", e.id, int'(snakeX_pos), e.x1);
                chk("p1_y", e.id, int'(snakeY_pos), e.y1);
                chk("p2_x", e.id, int'(snake2X_pos), e.x2);
                chk("p2_y", e.id, int'(snake2Y_pos), e.y2);
                chk("dir1", e.id, int'(dir1), e.d1);
                chk("dir2", e.id, int'(dir2), e.d2);
                chk("game_over", e.id, int'(game_over), e.go);
                chk("winner", e.id, int'(winner), e.win);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic press(input logic [15:0] kc);
        @(negedge Clk);
        keycode = kc;
        m_key(kc);
        repeat (2) @(negedge Clk);
        keycode = 16'h0000;
    endtask

    task automatic frame(input logic [19:0] rc);
        @(negedge Clk);
        rand_cord = rc;
        frame_clk = 1'b1;
        m_frame(int'(rc[19:10]), int'(rc[9:0]));
        push_exp();
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (12) @(negedge Clk);
    endtask

    task automatic probe_now();
        push_exp();
        @(negedge Clk);
        probe = 1'b1;
        @(negedge Clk);
        probe = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b1;
        m_reset();
        @(negedge Clk);
        reset = 1'b0;
        probe_now();
    endtask

    task automatic reset_mid_move();
        @(negedge Clk);
        frame_clk = 1'b1;
        m_reset();
        push_exp();
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        repeat (12) @(negedge Clk);
    endtask

    function automatic logic [7:0] rand_byte();
        return 8'(key_tbl[$urandom_range(0, 8)]);
    endfunction

    initial begin
        m_reset();
        repeat (3) @(negedge Clk);
        reset = 1'b0;
        probe_now();

        repeat (3) frame(FAR);
        frame({10'd200, 10'd240});
        repeat (2) frame({10'd200, 10'd240});
        press(16'h002C);
        probe_now();

        press(16'h0004); frame(FAR);
        press(16'h001A); frame(FAR);
        press(16'h0004); frame(FAR);
        press(16'h1A16); frame(FAR);

        do_reset();
        for (int i = 0; i < 100 && m_over == 0; i++) frame(FAR);
        frame(FAR);
        press(16'h2C00);
        probe_now();

        repeat (2) frame(FAR);
        reset_mid_move();
        frame(FAR);

        do_reset();
        press(16'h511A);
        repeat (6) frame(FAR);
        press(16'h5007);
        repeat (240) frame(FAR);

        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (m_over != 0 && $urandom_range(0, 1) == 1) begin
                press(($urandom_range(0, 1) == 1) ? 16'h002C : 16'h2C00);
                probe_now();
            end else begin
                press({rand_byte(), rand_byte()});
            end
            frame({10'($urandom_range(0, 639)), 10'($urandom_range(0, 479))});
        end

        repeat (20) @(negedge Clk);
        chk("scoreboard_drained", rec_id, q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
